mash_frac_ctrl: RTL and testbench
=================================

MASH_FRAC_CTRL -- requirements
Module: mash_frac_ctrl

Interface
REQ-001 Parameter BITS, default 8: width of the fractional word driven to the MASH.
REQ-002 Parameter NBITS, default 8: width of the integer divide word.
REQ-003 Parameter SETTLE, default 16: cycles from MASH release to the settled flag; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  run enable; low forces IDLE.
REQ-007 cfg_valid  input  1  new configuration offered.
REQ-008 cfg_ready  output  1  controller can accept a configuration.
REQ-009 cfg_int  input  NBITS  integer divide word.
REQ-010 cfg_frac  input  BITS  fractional word.
REQ-011 cfg_err  output  1  one-cycle pulse: configuration was rejected.
REQ-012 mash_f  output  BITS  fractional word driven to the MASH.
REQ-013 mash_clr  output  1  holds the MASH accumulators cleared.
REQ-014 mash_dn  input  3  MASH output, signed two's complement, legal range -1..+2.
REQ-015 div_ratio  output  NBITS  instantaneous divide ratio to the divider.
REQ-016 settled  output  1  high once SETTLE cycles have run since the last load.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SETTLE and RUN; there are no other states.
REQ-018 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in LOAD and SETTLE.
REQ-019 A transfer SHALL occur on any cycle where cfg_valid and cfg_ready are both 1; cfg_valid without cfg_ready SHALL be ignored.
REQ-020 A transfer with cfg_int < 2 SHALL be rejected: cfg_err pulses 1 on the next cycle, the registers stay unchanged, and the state stays unchanged.
REQ-021 An accepted transfer SHALL latch cfg_int and cfg_frac and enter LOAD on the next cycle.
REQ-022 IDLE to LOAD SHALL require en=1; in IDLE, transfers SHALL be accepted and latched even when en=0, but the FSM stays in IDLE.
REQ-023 LOAD SHALL last exactly one cycle, assert mash_clr, update mash_f to the latched fraction, then go to SETTLE.
REQ-024 SETTLE SHALL count SETTLE cycles with mash_clr=0, then go to RUN.
REQ-025 settled SHALL be 1 in RUN, and 0 in every other state.
REQ-026 In IDLE, mash_clr SHALL be 1 and div_ratio SHALL equal the latched integer.
REQ-027 In SETTLE and RUN, div_ratio SHALL be registered as latched_int + sign-extended mash_dn, one cycle after mash_dn is sampled.
REQ-028 The sum in REQ-027 SHALL be computed at NBITS+2 bits and saturated to the range [1, 2^NBITS-1].
REQ-029 A mash_dn value of -2, -3, -4 or +3 SHALL be treated as 0.
REQ-030 With en=0 in any state, the FSM SHALL go to IDLE on the next cycle; en=0 overrides a simultaneous transfer's LOAD entry, but the transfer still latches.
REQ-031 A transfer accepted in RUN SHALL restart the sequence: LOAD, then SETTLE, with settled dropping on the LOAD cycle.
REQ-032 With frac=0, the MASH SHALL still run and div_ratio SHALL equal the integer while mash_dn=0.

Reset
REQ-033 While rst_n=0, the outputs SHALL be: state IDLE, cfg_ready=1, cfg_err=0, mash_f=0, mash_clr=1, div_ratio=2, settled=0.
REQ-034 At reset, the latched integer SHALL be 2, the latched fraction 0, and the counter 0.
REQ-035 Reset asserted mid-SETTLE or mid-RUN SHALL abort immediately, with no pending transfer retained.
REQ-036 Reset deassertion SHALL take effect on the next rising clk edge.

Configuration
REQ-037 Macro MASH_FRAC_DITHER_EN, when defined, SHALL add a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset).
REQ-038 With MASH_FRAC_DITHER_EN, mash_f SHALL equal latched_frac with its LSB XORed with LFSR bit 0 in SETTLE and RUN; the LFSR advances every cycle outside IDLE.
REQ-039 Without MASH_FRAC_DITHER_EN, mash_f SHALL equal latched_frac exactly, and no LFSR logic SHALL exist.

Verification
REQ-040 Reset, then en=1 and a transfer of int=10, frac=0x40 -> LOAD for 1 cycle with mash_clr=1; settled rises 1+SETTLE cycles later; mash_f=0x40.
REQ-041 In RUN with int=10, drive mash_dn = -1, 0, +1, +2 -> div_ratio = 9, 10, 11, 12, each one cycle later.
REQ-042 Transfer of int=1 -> cfg_err pulses once; div_ratio, settled and the state are unchanged.
REQ-043 int=255 (NBITS=8) with mash_dn=+2 -> div_ratio saturates at 255; int=2 with mash_dn=-1 -> div_ratio=1.
REQ-044 Drop en mid-SETTLE -> IDLE next cycle, with mash_clr=1 and settled=0; then rst_n pulse low mid-RUN -> all outputs match REQ-033 asynchronously.
REQ-045 Transfer int=20 in RUN -> settled drops on the LOAD cycle, cfg_ready=0 through SETTLE, and div_ratio tracks 20 + mash_dn after settling.

Source files
------------

// File: rtl/mash_frac_ctrl.sv
// Fractional-N MASH controller: configuration handshake, LOAD/SETTLE/RUN sequencing
// and saturated divide-ratio generation. Define MASH_FRAC_DITHER_EN to add LSB dither.
module mash_frac_ctrl #(
  parameter int BITS   = 8,
  parameter int NBITS  = 8,
  parameter int SETTLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [NBITS-1:0] cfg_int,
  input  logic [BITS-1:0]  cfg_frac,
  output logic             cfg_err,
  output logic [BITS-1:0]  mash_f,
  output logic             mash_clr,
  input  logic [2:0]       mash_dn,
  output logic [NBITS-1:0] div_ratio,
  output logic             settled
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int SUM_W = NBITS + 2;
  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t           state, nxt;
  logic [NBITS-1:0] int_q, int_d;
  logic [BITS-1:0]  frac_q, frac_d;
  logic [7:0]       cnt;
  logic             xfer, accept;
  logic [2:0]       dn_eff;
  logic [SUM_W-1:0] sum;
  logic [NBITS-1:0] sat;

  assign xfer   = cfg_valid & cfg_ready;
  assign accept = xfer & (cfg_int >= NBITS'(2));
  assign int_d  = accept ? cfg_int  : int_q;
  assign frac_d = accept ? cfg_frac : frac_q;

  // Only -1..+2 are legal MASH outputs; anything else contributes nothing.
  always_comb begin
    dn_eff = 3'b000;
    case (mash_dn)
      3'b111, 3'b000, 3'b001, 3'b010: dn_eff = mash_dn;
      default:                        dn_eff = 3'b000;
    endcase
  end

  assign sum = {2'b00, int_q} + {{(NBITS - 1){dn_eff[2]}}, dn_eff};

  always_comb begin
    if (sum[SUM_W-1] || (sum == '0))
      sat = NBITS'(1);
    else if (sum[SUM_W-2:NBITS] != '0)
      sat = '1;
    else
      sat = sum[NBITS-1:0];
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    nxt = state;
    if (!en) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (accept) nxt = ST_LOAD;
        ST_LOAD:   nxt = ST_SETTLE;
        ST_SETTLE: if (cnt == CNT_LAST) nxt = ST_RUN;
        ST_RUN:    if (accept) nxt = ST_LOAD;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; outputs are registered
  // from the next state so they change together with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      int_q     <= NBITS'(2);
      frac_q    <= '0;
      cnt       <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      mash_clr  <= 1'b1;
      settled   <= 1'b0;
      div_ratio <= NBITS'(2);
    end else begin
      state     <= nxt;
      int_q     <= int_d;
      frac_q    <= frac_d;
      cnt       <= (state == ST_SETTLE) ? cnt + 8'd1 : 8'd0;
      cfg_ready <= (nxt == ST_IDLE) || (nxt == ST_RUN);
      cfg_err   <= xfer & ~accept;
      mash_clr  <= (nxt == ST_IDLE) || (nxt == ST_LOAD);
      settled   <= (nxt == ST_RUN);
      // Track the MASH only while it is live; otherwise present the plain integer.
      if (((state == ST_SETTLE) || (state == ST_RUN)) && (nxt != ST_IDLE))
        div_ratio <= sat;
      else
        div_ratio <= int_d;
    end
  end

`ifdef MASH_FRAC_DITHER_EN
  logic [15:0] lfsr;
  logic        dith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 16'hACE1;
    else if (state != ST_IDLE)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign dith   = lfsr[0] & ((state == ST_SETTLE) || (state == ST_RUN));
  assign mash_f = frac_q ^ {{(BITS - 1){1'b0}}, dith};
`else
  assign mash_f = frac_q;
`endif

endmodule

// File: tb/tb_mash_frac_ctrl.sv
// Directed self-checking bench for mash_frac_ctrl (default build, BITS=NBITS=8, SETTLE=16).
module tb_mash_frac_ctrl;

  localparam int SETTLE_C = 16;

  logic       clk = 1'b0;
  logic       rst_n, en, cfg_valid, cfg_ready, cfg_err, mash_clr, settled;
  logic [7:0] cfg_int, cfg_frac, mash_f, div_ratio;
  logic [2:0] mash_dn;

  int vectors = 0;
  int miscompares = 0;

  mash_frac_ctrl #(.BITS(8), .NBITS(8), .SETTLE(SETTLE_C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .cfg_err   (cfg_err),
    .mash_f    (mash_f),
    .mash_clr  (mash_clr),
    .mash_dn   (mash_dn),
    .div_ratio (div_ratio),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   32'(cfg_ready), 32'd1);
    check({tag, "_err"},     32'(cfg_err),   32'd0);
    check({tag, "_f"},       32'(mash_f),    32'd0);
    check({tag, "_clr"},     32'(mash_clr),  32'd1);
    check({tag, "_div"},     32'(div_ratio), 32'd2);
    check({tag, "_settled"}, 32'(settled),   32'd0);
  endtask

  // Offer a configuration in RUN/IDLE (en=1) and walk LOAD + SETTLE into RUN.
  task automatic do_load(input logic [7:0] i, input logic [7:0] f);
    mash_dn   = 3'b000;
    cfg_valid = 1'b1;
    cfg_int   = i;
    cfg_frac  = f;
    step;
    cfg_valid = 1'b0;
    check("load_clr",     32'(mash_clr),  32'd1);
    check("load_settled", 32'(settled),   32'd0);
    check("load_ready",   32'(cfg_ready), 32'd0);
    check("load_f",       32'(mash_f),    32'(f));
    for (int k = 0; k < SETTLE_C; k++) begin
      step;
      check("settle_ready",   32'(cfg_ready), 32'd0);
      check("settle_settled", 32'(settled),   32'd0);
      check("settle_clr",     32'(mash_clr),  32'd0);
    end
    step;
    check("run_settled", 32'(settled),   32'd1);
    check("run_ready",   32'(cfg_ready), 32'd1);
    check("run_div",     32'(div_ratio), 32'(i));
  endtask

  logic [2:0] dn_tab  [7] = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100};
  logic [7:0] exp_tab [7] = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd10, 8'd10, 8'd10};

  initial begin
    rst_n = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_int = 8'd0; cfg_frac = 8'd0; mash_dn = 3'b000;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    en    = 1'b1;

    // Basic bring-up with int=10, frac=0x40.
    do_load(8'd10, 8'h40);
    check("run_f", 32'(mash_f), 32'h40);

    // MASH tracking and illegal-value suppression.
    for (int k = 0; k < 7; k++) begin
      mash_dn = dn_tab[k];
      step;
      check("track_div", 32'(div_ratio), 32'(exp_tab[k]));
    end
    mash_dn = 3'b000;
    step;

    // Rejected configuration in RUN.
    cfg_valid = 1'b1; cfg_int = 8'd1; cfg_frac = 8'h11;
    step;
    cfg_valid = 1'b0;
    check("rej_err",     32'(cfg_err),   32'd1);
    check("rej_settled", 32'(settled),   32'd1);
    check("rej_ready",   32'(cfg_ready), 32'd1);
    check("rej_div",     32'(div_ratio), 32'd10);
    check("rej_f",       32'(mash_f),    32'h40);
    step;
    check("rej_err_once", 32'(cfg_err), 32'd0);
    check("rej_state",    32'(settled), 32'd1);

    // Upper saturation.
    do_load(8'd255, 8'h00);
    mash_dn = 3'b010; step;
    check("sat_hi", 32'(div_ratio), 32'd255);
    mash_dn = 3'b111; step;
    check("sat_hi_m1", 32'(div_ratio), 32'd254);

    // Lower bound.
    do_load(8'd2, 8'h01);
    mash_dn = 3'b111; step;
    check("sat_lo", 32'(div_ratio), 32'd1);

    // Restart from RUN with int=20.
    do_load(8'd20, 8'h33);
    mash_dn = 3'b001; step;
    check("i20_p1", 32'(div_ratio), 32'd21);
    mash_dn = 3'b111; step;
    check("i20_m1", 32'(div_ratio), 32'd19);
    mash_dn = 3'b000; step;

    // Drop en mid-SETTLE.
    cfg_valid = 1'b1; cfg_int = 8'd30; cfg_frac = 8'h05;
    step;
    cfg_valid = 1'b0;
    step; step; step;
    check("mid_settle_clr", 32'(mash_clr), 32'd0);
    en = 1'b0;
    step;
    check("en_off_clr",     32'(mash_clr),  32'd1);
    check("en_off_settled", 32'(settled),   32'd0);
    check("en_off_ready",   32'(cfg_ready), 32'd1);
    check("en_off_div",     32'(div_ratio), 32'd30);

    // Transfer in IDLE with en=0 latches but does not leave IDLE.
    cfg_valid = 1'b1; cfg_int = 8'd50; cfg_frac = 8'h22;
    step;
    cfg_valid = 1'b0;
    check("idle_xfer_f",   32'(mash_f),    32'h22);
    check("idle_xfer_div", 32'(div_ratio), 32'd50);
    step;
    check("idle_stay_clr",   32'(mash_clr),  32'd1);
    check("idle_stay_ready", 32'(cfg_ready), 32'd1);

    // Back to RUN, then asynchronous reset mid-RUN.
    en = 1'b1;
    do_load(8'd40, 8'h80);
    mash_dn = 3'b001; step;
    check("pre_rst_div", 32'(div_ratio), 32'd41);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    step;
    rst_n = 1'b1;
    step;
    check("post_rst_div", 32'(div_ratio), 32'd2);
    check("post_rst_clr", 32'(mash_clr),  32'd1);
    check("post_rst_f",   32'(mash_f),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
